sram_access_ctrl: RTL and testbench

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

---
 rtl/sram_access_ctrl_if.sv | 39 +++
 rtl/sram_access_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// Request/response and SRAM pin bundle for sram_access_ctrl.
// The slave modport is the controller. The master modport is the requester
// together with the SRAM device that it drives.
interface sram_access_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  // requester -> controller
  logic          iWrReq;
  logic [AW-1:0] iWrAddr;
  logic [DW-1:0] iWrData;
  logic          iRdStart;
  // controller -> SRAM pins
  logic          oCsnRam;
  logic          oWrnRam;
  logic [AW-1:0] oAddrRam;
  logic [DW-1:0] oWtDtRam;
  // SRAM -> controller
  logic [DW-1:0] iRdDtRam;
  // controller -> requester
  logic [DW-1:0] oRdDt;
  logic          oRdVld;
  logic [AW-1:0] oRdIdx;
  logic          oRdDone;
  logic          oBusy;
  logic          oErr;

  modport slave (
    input  iWrReq, iWrAddr, iWrData, iRdStart, iRdDtRam,
    output oCsnRam, oWrnRam, oAddrRam, oWtDtRam,
    output oRdDt, oRdVld, oRdIdx, oRdDone, oBusy, oErr
  );

  modport master (
    output iWrReq, iWrAddr, iWrData, iRdStart, iRdDtRam,
    input  oCsnRam, oWrnRam, oAddrRam, oWtDtRam,
    input  oRdDt, oRdVld, oRdIdx, oRdDone, oBusy, oErr
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Single-port SRAM access controller.
// It performs single-word writes with a range check, and full read sweeps
// over addresses 0..DEPTH-1. Read data returns through a two-stage pipeline:
// the SRAM answers one cycle after the address, and the controller then
// registers the answer.
module sram_access_ctrl #(
  parameter int DEPTH = 10,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic              iClk12M,
  input  logic              iRst,
  sram_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // One extra bit so that DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  state_t        state_q, state_d;
  logic          csn_q, csn_d;
  logic          wrn_q, wrn_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wtdt_q, wtdt_d;
  logic          drain_q, drain_d;
  logic          err_q, err_d;

  // Stage 1 of the read pipeline: this tags the cycle in which the SRAM is
  // presenting data.
  logic          p1_vld_q, p1_vld_d;
  logic [AW-1:0] p1_idx_q, p1_idx_d;
  logic          p1_last_q, p1_last_d;

  // Stage 2 of the read pipeline: the registered result seen by the requester.
  logic [DW-1:0] rd_dt_q, rd_dt_d;
  logic          rd_vld_q, rd_vld_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic          rd_done_q, rd_done_d;

  logic wr_in_range;
  assign wr_in_range = ({1'b0, bus.iWrAddr} < DEPTH_EXT);

  // Next state and next SRAM pin values. The pins are registered, so every
  // transition also sets the values the pins carry during the next state.
  always_comb begin
    state_d = state_q;
    csn_d   = csn_q;
    wrn_d   = wrn_q;
    addr_d  = addr_q;
    wtdt_d  = wtdt_q;
    drain_d = drain_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        csn_d = 1'b1;
        wrn_d = 1'b1;
        // A write takes priority; a read start in the same cycle is dropped.
        if (bus.iWrReq) begin
          if (wr_in_range) begin
            state_d = WRITE;
            csn_d   = 1'b0;
            wrn_d   = 1'b0;
            addr_d  = bus.iWrAddr;
            wtdt_d  = bus.iWrData;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.iRdStart) begin
          state_d = READ;
          csn_d   = 1'b0;
          wrn_d   = 1'b1;
          addr_d  = '0;
        end
      end

      WRITE: begin
        state_d = IDLE;
        csn_d   = 1'b1;
        wrn_d   = 1'b1;
      end

      READ: begin
        // The address stops at the last word; it never steps past it.
        if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          csn_d   = 1'b1;
          drain_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      DRAIN: begin
        // Two flush cycles let the last word leave the read pipeline.
        if (drain_q) begin
          state_d = IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        csn_d   = 1'b1;
        wrn_d   = 1'b1;
      end
    endcase
  end

  // Read pipeline: tag each READ cycle, then capture SRAM data one cycle later.
  always_comb begin
    p1_vld_d  = (state_q == READ);
    p1_idx_d  = addr_q;
    p1_last_d = (state_q == READ) && (addr_q == LAST_ADDR);

    rd_vld_d  = p1_vld_q;
    rd_done_d = p1_vld_q && p1_last_q;
    rd_dt_d   = rd_dt_q;
    rd_idx_d  = rd_idx_q;
    if (p1_vld_q) begin
      rd_dt_d  = bus.iRdDtRam;
      rd_idx_d = p1_idx_q;
    end
  end

  // All state registers. Reset also clears the pipeline, so an aborted sweep
  // produces no trailing strobes.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state_q   <= IDLE;
      csn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      addr_q    <= '0;
      wtdt_q    <= '0;
      drain_q   <= 1'b0;
      err_q     <= 1'b0;
      p1_vld_q  <= 1'b0;
      p1_idx_q  <= '0;
      p1_last_q <= 1'b0;
      rd_dt_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      csn_q     <= csn_d;
      wrn_q     <= wrn_d;
      addr_q    <= addr_d;
      wtdt_q    <= wtdt_d;
      drain_q   <= drain_d;
      err_q     <= err_d;
      p1_vld_q  <= p1_vld_d;
      p1_idx_q  <= p1_idx_d;
      p1_last_q <= p1_last_d;
      rd_dt_q   <= rd_dt_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
      rd_done_q <= rd_done_d;
    end
  end

  assign bus.oCsnRam  = csn_q;
  assign bus.oWrnRam  = wrn_q;
  assign bus.oAddrRam = addr_q;
  assign bus.oWtDtRam = wtdt_q;
  assign bus.oRdDt    = rd_dt_q;
  assign bus.oRdVld   = rd_vld_q;
  assign bus.oRdIdx   = rd_idx_q;
  assign bus.oRdDone  = rd_done_q;
  assign bus.oBusy    = (state_q != IDLE);
  assign bus.oErr     = err_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl.
// It uses a behavioural 16x16 SRAM, keeps a reference copy of the memory
// contents, and keeps a queue of the read results each sweep should return.
module tb_sram_access_ctrl;
  localparam int DEPTH = 10;
  localparam int AW    = 4;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_access_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  sram_access_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .iClk12M (clk),
    .iRst    (rst),
    .bus     (bus)
  );

  // SRAM device: synchronous write, read data one cycle after the address.
  logic [DW-1:0] sram_mem [16] = '{default: '0};
  logic [DW-1:0] sram_rd_q = '0;
  always @(posedge clk) begin
    if (!bus.oCsnRam && !bus.oWrnRam) sram_mem[bus.oAddrRam] <= bus.oWtDtRam;
    sram_rd_q <= sram_mem[bus.oAddrRam];
  end
  assign bus.iRdDtRam = sram_rd_q;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            cyc;
    logic          last;
  } exp_t;

  exp_t          exp_q [$];
  logic [DW-1:0] exp_mem [16] = '{default: '0};
  int            cyc       = 0;
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Advance one cycle, sample 1ns after the edge, and score any read output.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.oRdVld) begin
      chk("rdvld_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_idx",   32'(bus.oRdIdx),  32'(e.idx));
        chk("rd_data",  32'(bus.oRdDt),   32'(e.data));
        chk("rd_cycle", 32'(cyc),         32'(e.cyc));
        chk("rd_done",  32'(bus.oRdDone), 32'(e.last));
      end
    end else if (bus.oRdDone) begin
      chk("done_without_vld", 32'(bus.oRdDone), 32'd0);
    end
    if (!bus.oCsnRam) chk("addr_in_range", 32'(bus.oAddrRam < AW'(DEPTH)), 32'd1);
  endtask

  task automatic check_reset();
    chk("rst_csn",  32'(bus.oCsnRam),  32'd1);
    chk("rst_wrn",  32'(bus.oWrnRam),  32'd1);
    chk("rst_addr", 32'(bus.oAddrRam), 32'd0);
    chk("rst_wtdt", 32'(bus.oWtDtRam), 32'd0);
    chk("rst_rddt", 32'(bus.oRdDt),    32'd0);
    chk("rst_vld",  32'(bus.oRdVld),   32'd0);
    chk("rst_idx",  32'(bus.oRdIdx),   32'd0);
    chk("rst_done", 32'(bus.oRdDone),  32'd0);
    chk("rst_busy", 32'(bus.oBusy),    32'd0);
    chk("rst_err",  32'(bus.oErr),     32'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bool_ok: begin end
    bus.iWrReq  = 1'b1;
    bus.iWrAddr = a;
    bus.iWrData = d;
    tick();
    bus.iWrReq = 1'b0;
    if (int'(a) < DEPTH) begin
      chk("wr_csn",  32'(bus.oCsnRam),  32'd0);
      chk("wr_wrn",  32'(bus.oWrnRam),  32'd0);
      chk("wr_addr", 32'(bus.oAddrRam), 32'(a));
      chk("wr_data", 32'(bus.oWtDtRam), 32'(d));
      chk("wr_busy", 32'(bus.oBusy),    32'd1);
      chk("wr_err",  32'(bus.oErr),     32'd0);
      exp_mem[a] = d;
      tick();
      chk("wr_end_csn",  32'(bus.oCsnRam), 32'd1);
      chk("wr_end_busy", 32'(bus.oBusy),   32'd0);
    end else begin
      chk("oor_err",  32'(bus.oErr),    32'd1);
      chk("oor_csn",  32'(bus.oCsnRam), 32'd1);
      chk("oor_busy", 32'(bus.oBusy),   32'd0);
      tick();
      chk("oor_err_pulse", 32'(bus.oErr),    32'd0);
      chk("oor_csn_after", 32'(bus.oCsnRam), 32'd1);
    end
  endtask

  // Full sweep. With a nonzero inject_at, a write to address 2 and a read
  // start are both pulsed in that sweep cycle; neither may have any effect.
  task automatic sweep(input int inject_at);
    int n0;
    exp_t e;
    n0 = cyc;
    bus.iRdStart = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      e.idx  = k;
      e.data = exp_mem[k];
      e.cyc  = n0 + 3 + k;
      e.last = (k == DEPTH - 1);
      exp_q.push_back(e);
    end
    tick();
    bus.iRdStart = 1'b0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      if (i <= DEPTH) begin
        chk("sw_csn",  32'(bus.oCsnRam),  32'd0);
        chk("sw_wrn",  32'(bus.oWrnRam),  32'd1);
        chk("sw_addr", 32'(bus.oAddrRam), 32'(i - 1));
      end else begin
        chk("drain_csn", 32'(bus.oCsnRam), 32'd1);
      end
      chk("sw_busy", 32'(bus.oBusy), 32'd1);
      if (i == inject_at) begin
        bus.iWrReq   = 1'b1;
        bus.iWrAddr  = 4'd2;
        bus.iWrData  = 16'hDEAD;
        bus.iRdStart = 1'b1;
      end
      tick();
      bus.iWrReq   = 1'b0;
      bus.iRdStart = 1'b0;
    end
    chk("sw_end_busy", 32'(bus.oBusy),   32'd0);
    chk("sw_end_csn",  32'(bus.oCsnRam), 32'd1);
    chk("sw_all_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n0;
    bus.iWrReq   = 1'b0;
    bus.iWrAddr  = '0;
    bus.iWrData  = '0;
    bus.iRdStart = 1'b0;

    // Reset values, then a write on the very first cycle after reset.
    rst = 1'b1;
    tick();
    tick();
    check_reset();
    rst = 1'b0;
    wr(4'd3, 16'h1234);
    sweep(0);

    // Known pattern at every address, then a full sweep.
    for (int k = 0; k < DEPTH; k++) wr(AW'(k), 16'((k + 1) * 16'h0101));
    sweep(0);

    // Out-of-range writes are rejected and leave memory untouched.
    wr(4'd10, 16'hAAAA);
    wr(4'd15, 16'h5555);
    sweep(0);

    // Write and read start together: only the write happens.
    bus.iWrReq   = 1'b1;
    bus.iWrAddr  = 4'd5;
    bus.iWrData  = 16'hBEEF;
    bus.iRdStart = 1'b1;
    tick();
    bus.iWrReq   = 1'b0;
    bus.iRdStart = 1'b0;
    chk("cf_csn",  32'(bus.oCsnRam),  32'd0);
    chk("cf_wrn",  32'(bus.oWrnRam),  32'd0);
    chk("cf_addr", 32'(bus.oAddrRam), 32'd5);
    chk("cf_data", 32'(bus.oWtDtRam), 32'hBEEF);
    exp_mem[5] = 16'hBEEF;
    tick();
    chk("cf_idle_busy", 32'(bus.oBusy), 32'd0);
    for (int i = 0; i < DEPTH + 4; i++) tick();
    chk("cf_no_read", 32'(bus.oRdVld), 32'd0);

    // Requests pulsed during a sweep are ignored.
    sweep(4);
    sweep(0);

    // Reset in the middle of a sweep aborts it cleanly.
    n0 = cyc;
    bus.iRdStart = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      exp_t e;
      e.idx  = k;
      e.data = exp_mem[k];
      e.cyc  = n0 + 3 + k;
      e.last = (k == DEPTH - 1);
      exp_q.push_back(e);
    end
    tick();
    bus.iRdStart = 1'b0;
    while (cyc < n0 + 5) tick();
    rst = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH + 4; i++) tick();
    chk("abort_no_vld", 32'(bus.oRdVld), 32'd0);
    sweep(0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
